// File: rtl/prog_counter_pkg.sv
// prog_counter shared types and constants.
// FSM state encoding plus mode/direction codes.
package prog_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_WRAP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/prog_counter_step.sv
// prog_counter next-value datapath.
// Clamped up/down advance and terminal detect.
module prog_counter_step
  import prog_counter_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int STEP_WIDTH = 8
) (
  input  logic [WIDTH-1:0]      count,
  input  logic                  dir,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic [WIDTH-1:0]      limit,
  output logic [WIDTH-1:0]      nxt,
  output logic                  at_term
);

  logic [WIDTH:0] step_x;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // Zero step acts as one; math carried at WIDTH+1 bits.
  always_comb begin
    step_x = '0;
    step_x[STEP_WIDTH-1:0] = step;
    if (step == '0) step_x = {{WIDTH{1'b0}}, 1'b1};
    sum  = {1'b0, count} + step_x;
    diff = {1'b0, count} - step_x;
  end

  // Up clamps to limit, down clamps to zero on borrow.
  always_comb begin
    nxt     = count;
    at_term = 1'b0;
    if (dir == DIR_UP) begin
      at_term = (count >= limit);
      if (sum >= {1'b0, limit}) nxt = limit;
      else nxt = sum[WIDTH-1:0];
    end else begin
      at_term = (count == '0);
      if (diff[WIDTH]) nxt = '0;
      else nxt = diff[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/prog_counter.sv
// prog_counter top: count register, one-shot FSM,
// terminal-count pulse and prescaled output slice.
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int STEP_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  en,
  input  logic                  clear,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  input  logic                  dir,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic [WIDTH-1:0]      limit,
  input  logic                  mode,
  input  logic                  start,
  output logic [WIDTH-1:0]      count,
  output logic [OUT_WIDTH-1:0]  cout,
  output logic                  tc,
  output logic                  busy,
  output logic                  done
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  state_e           state_q, state_d;

  logic [WIDTH-1:0] nxt;
  logic             at_term;
  logic [WIDTH-1:0] s_val;
  logic [WIDTH-1:0] t_val;

  prog_counter_step #(
    .WIDTH      (WIDTH),
    .STEP_WIDTH (STEP_WIDTH)
  ) u_step (
    .count   (count_q),
    .dir     (dir),
    .step    (step),
    .limit   (limit),
    .nxt     (nxt),
    .at_term (at_term)
  );

  assign s_val = (dir == DIR_DOWN) ? limit : '0;
  assign t_val = (dir == DIR_DOWN) ? '0 : limit;

  // Priority: clear > load > start > advance.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    state_d = state_q;
    if (clear) begin
      count_d = '0;
      state_d = IDLE;
    end else if (load) begin
      count_d = load_value;
    end else if (mode == MODE_WRAP) begin
      state_d = IDLE;
      if (en) begin
        if (at_term) begin
          count_d = s_val;
          tc_d    = 1'b1;
        end else begin
          count_d = nxt;
        end
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            count_d = s_val;
            state_d = RUN;
          end
        end
        RUN: begin
          if (start) begin
            count_d = s_val;
          end else if (en) begin
            if (at_term || nxt == t_val) begin
              count_d = t_val;
              tc_d    = 1'b1;
              state_d = DONE;
            end else begin
              count_d = nxt;
            end
          end
        end
        DONE: begin
          if (start) begin
            count_d = s_val;
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers with async active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      state_q <= IDLE;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      state_q <= state_d;
    end
  end

  assign count = count_q;
  assign cout  = count_q[WIDTH-1 -: OUT_WIDTH];
  assign tc    = tc_q;
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_prog_counter.sv
// prog_counter directed self-checking bench.
// Linear directed steps with hand-computed expectations.
module tb_prog_counter;

  logic        clk;
  logic        resetn;
  logic        en;
  logic        clear;
  logic        load;
  logic [31:0] load_value;
  logic        dir;
  logic [7:0]  step;
  logic [31:0] limit;
  logic        mode;
  logic        start;
  logic [31:0] count;
  logic [7:0]  cout;
  logic        tc;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  prog_counter #(
    .WIDTH      (32),
    .OUT_WIDTH  (8),
    .STEP_WIDTH (8)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .en         (en),
    .clear      (clear),
    .load       (load),
    .load_value (load_value),
    .dir        (dir),
    .step       (step),
    .limit      (limit),
    .mode       (mode),
    .start      (start),
    .count      (count),
    .cout       (cout),
    .tc         (tc),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int up_c[6]  = '{1, 2, 3, 4, 0, 1};
  int up_t[6]  = '{0, 0, 0, 0, 1, 0};
  int cu_c[4]  = '{4, 8, 10, 0};
  int cd_c[4]  = '{6, 2, 0, 10};
  int cx_t[4]  = '{0, 0, 0, 1};
  int os_c[3]  = '{2, 1, 0};
  int os_t[3]  = '{0, 0, 1};

  initial begin
    resetn = 0; en = 0; clear = 0; load = 0;
    load_value = 0; dir = 0; step = 1;
    limit = 0; mode = 0; start = 0;
    tick();
    tick();
    chk("rst_count", count, 0);
    chk("rst_tc", {31'd0, tc}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);

    // slice after load
    resetn = 1;
    load = 1; load_value = 32'hA500_0000;
    tick();
    chk("load_count", count, 32'hA500_0000);
    chk("cout", {24'd0, cout}, 32'h0000_00A5);

    // async reset mid-count
    load_value = 5;
    tick();
    load = 0; en = 1; limit = 100;
    tick();
    chk("mid_count", count, 6);
    #1 resetn = 0;
    #1;
    chk("async_count", count, 0);
    chk("async_tc", {31'd0, tc}, 0);
    en = 0;
    tick();
    resetn = 1;

    // wrap up, limit 4
    mode = 0; dir = 0; limit = 4; step = 1; en = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("wrap_c%0d", i), count, up_c[i]);
      chk($sformatf("wrap_t%0d", i), {31'd0, tc}, up_t[i]);
    end
    en = 0;

    // step clamp up
    clear = 1;
    tick();
    clear = 0;
    chk("clr_count", count, 0);
    limit = 10; step = 4; en = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("cup_c%0d", i), count, cu_c[i]);
      chk($sformatf("cup_t%0d", i), {31'd0, tc}, cx_t[i]);
    end
    en = 0;

    // step clamp down
    dir = 1; load = 1; load_value = 10;
    tick();
    load = 0;
    chk("cdn_load", count, 10);
    en = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("cdn_c%0d", i), count, cd_c[i]);
      chk($sformatf("cdn_t%0d", i), {31'd0, tc}, cx_t[i]);
    end
    en = 0;

    // one-shot down, limit 3
    mode = 1; dir = 1; limit = 3; step = 1;
    start = 1;
    tick();
    start = 0;
    chk("os_start_c", count, 3);
    chk("os_busy", {31'd0, busy}, 1);
    chk("os_done0", {31'd0, done}, 0);
    en = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("os_c%0d", i), count, os_c[i]);
      chk($sformatf("os_t%0d", i), {31'd0, tc}, os_t[i]);
    end
    chk("os_done1", {31'd0, done}, 1);
    chk("os_busy1", {31'd0, busy}, 0);
    tick();
    chk("os_hold", count, 0);
    chk("os_hold_tc", {31'd0, tc}, 0);
    chk("os_hold_done", {31'd0, done}, 1);
    start = 1;
    tick();
    start = 0;
    chk("os_re_c", count, 3);
    chk("os_re_busy", {31'd0, busy}, 1);
    chk("os_re_done", {31'd0, done}, 0);
    en = 0;

    // priority
    mode = 0; dir = 0; limit = 100;
    load = 1; load_value = 7;
    tick();
    chk("pri_pre", count, 7);
    clear = 1; load = 1; en = 1; load_value = 9;
    tick();
    clear = 0;
    chk("pri_clr", count, 0);
    tick();
    load = 0;
    chk("pri_load", count, 9);
    tick();
    chk("pri_adv", count, 10);
    en = 0;

    // step 0 acts as 1
    clear = 1;
    tick();
    clear = 0;
    step = 0; en = 1;
    tick();
    chk("s0_c1", count, 1);
    tick();
    chk("s0_c2", count, 2);

    // loaded past limit
    step = 1; limit = 10; en = 0;
    load = 1; load_value = 20;
    tick();
    load = 0;
    chk("over_load", count, 20);
    en = 1;
    tick();
    chk("over_c", count, 0);
    chk("over_tc", {31'd0, tc}, 1);

    // limit 0 wrap
    limit = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("l0_c%0d", i), count, 0);
      chk($sformatf("l0_t%0d", i), {31'd0, tc}, 1);
    end
    en = 0;
    tick();
    chk("l0_off_tc", {31'd0, tc}, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
